// File: rtl/mux_key_reverse_lookup.sv
// mux_key_reverse_lookup
//   Programmable key/data table plus a sequential reverse (data -> key) search.
//   The table is exported on a flat lut bus in the packing the key-indexed mux
//   consumes: entry n at [P*(n+1)-1:P*n], key in the MSBs, P = KEY_LEN+DATA_LEN.
//   A search walks the registered table one entry per cycle from index 0 and
//   reports the lowest-index valid entry whose data matches.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   wr_en/wr_idx/wr_key/wr_data
//                         single-entry table write; indices >= NR_KEY are dropped
//   lut                   registered table contents, packed as above
//   req_valid/req_ready/req_data
//                         search request handshake (ready only while idle)
//   rsp_valid/rsp_ready/rsp_hit/rsp_key/rsp_idx
//                         search response, held until rsp_ready
//   default_key           only with MUX_KEY_REVLUT_DEFAULT_EN: key reported on a
//                         miss, captured when the request is accepted
//
// Build option
//   MUX_KEY_REVLUT_DEFAULT_EN  adds default_key; otherwise a miss reports key 0.
//   IDX_LEN must satisfy 2**IDX_LEN >= NR_KEY.

// One table entry: storage, valid bit and its data comparator.
module mux_key_revlut_entry #(
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 4,
  parameter int IDX_LEN  = 2,
  parameter int IDX      = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [IDX_LEN-1:0]  wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic [DATA_LEN-1:0] cmp_data,
  output logic [KEY_LEN-1:0]  key,
  output logic [DATA_LEN-1:0] data,
  output logic                vld,
  output logic                hit
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key  <= '0;
      data <= '0;
      vld  <= 1'b0;
    end else if (wr_en && wr_idx == IDX_LEN'(IDX)) begin
      key  <= wr_key;
      data <= wr_data;
      vld  <= 1'b1;
    end
  end

  // Never-written entries must not match, even against data 0.
  assign hit = vld && (data == cmp_data);
endmodule

module mux_key_reverse_lookup #(
  parameter int NR_KEY   = 4,
  parameter int KEY_LEN  = 2,
  parameter int DATA_LEN = 4,
  parameter int IDX_LEN  = 2,
  localparam int P       = KEY_LEN + DATA_LEN
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_LEN-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]    wr_key,
  input  logic [DATA_LEN-1:0]   wr_data,
  output logic [NR_KEY*P-1:0]   lut,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_LEN-1:0]   req_data,
`ifdef MUX_KEY_REVLUT_DEFAULT_EN
  input  logic [KEY_LEN-1:0]    default_key,
`endif
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_hit,
  output logic [KEY_LEN-1:0]    rsp_key,
  output logic [IDX_LEN-1:0]    rsp_idx
);
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_t;

  typedef struct packed {
    logic               hit;
    logic [KEY_LEN-1:0] key;
    logic [IDX_LEN-1:0] idx;
  } rsp_t;

  localparam logic [IDX_LEN-1:0] LAST_IDX = IDX_LEN'(NR_KEY - 1);

  state_t                            state_q, state_d;
  logic [IDX_LEN-1:0]                scan_q, scan_d;
  logic [DATA_LEN-1:0]               req_q, req_d;
  logic [KEY_LEN-1:0]                dflt_q, dflt_d;
  rsp_t                              rsp_q, rsp_d;
  logic                              rdy_q, rdy_d;

  logic [NR_KEY-1:0][KEY_LEN-1:0]    ent_key;
  logic [NR_KEY-1:0][DATA_LEN-1:0]   ent_data;
  logic [NR_KEY-1:0]                 ent_vld;
  logic [NR_KEY-1:0]                 ent_hit;
  logic                              cur_hit;
  logic [KEY_LEN-1:0]                cur_key;

  // Comparators see the registered table, so a write landing on the entry
  // under compare takes effect only after that compare.
  for (genvar n = 0; n < NR_KEY; n++) begin : g_ent
    mux_key_revlut_entry #(
      .KEY_LEN (KEY_LEN),
      .DATA_LEN(DATA_LEN),
      .IDX_LEN (IDX_LEN),
      .IDX     (n)
    ) u_ent (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_idx  (wr_idx),
      .wr_key  (wr_key),
      .wr_data (wr_data),
      .cmp_data(req_q),
      .key     (ent_key[n]),
      .data    (ent_data[n]),
      .vld     (ent_vld[n]),
      .hit     (ent_hit[n])
    );
    assign lut[P*n +: P] = {ent_key[n], ent_data[n]};
  end

`ifdef MUX_KEY_REVLUT_DEFAULT_EN
  assign dflt_d = (state_q == S_IDLE && req_valid && rdy_q) ? default_key : dflt_q;
`else
  assign dflt_d = '0;
`endif

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    req_d   = req_q;
    rsp_d   = rsp_q;
    cur_hit = 1'b0;
    cur_key = '0;
    for (int n = 0; n < NR_KEY; n++) begin
      if (scan_q == IDX_LEN'(n)) begin
        cur_hit = ent_hit[n];
        cur_key = ent_key[n];
      end
    end
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && rdy_q) begin
          state_d = S_SCAN;
          scan_d  = '0;
          req_d   = req_data;
        end
      end
      S_SCAN: begin
        if (cur_hit) begin
          state_d = S_RESP;
          rsp_d   = '{hit: 1'b1, key: cur_key, idx: scan_q};
        end else if (scan_q == LAST_IDX) begin
          state_d = S_RESP;
          rsp_d   = '{hit: 1'b0, key: dflt_q, idx: '0};
        end else begin
          scan_d  = scan_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          rsp_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Registered ready: low through reset and for the first cycle after it.
    rdy_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      scan_q  <= '0;
      req_q   <= '0;
      dflt_q  <= '0;
      rsp_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scan_q  <= scan_d;
      req_q   <= req_d;
      dflt_q  <= dflt_d;
      rsp_q   <= rsp_d;
      rdy_q   <= rdy_d;
    end
  end

  assign req_ready = rdy_q;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_hit   = rsp_q.hit;
  assign rsp_key   = rsp_q.key;
  assign rsp_idx   = rsp_q.idx;
endmodule
